// File: rtl/fp_series_add_pkg.sv
// Shared constants, field layout and helpers for the fp_series_add accumulator.
package fp_series_add_pkg;
  localparam int SIGN_BIT = 31;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  // Leading-zero count over a 28-bit magnitude; 28 means all zero.
  function automatic logic [4:0] lzc28(input logic [27:0] v);
    lzc28 = 5'd28;
    for (int i = 0; i < 28; i++)
      if (v[i]) lzc28 = 5'(27 - i);
  endfunction
endpackage

// File: rtl/fp_series_add_fp_add32.sv
// Single-cycle combinational IEEE-754 single adder, flush-to-zero.
// Rounding is truncation unless FP_SERIES_ADD_RNE_EN selects round-to-nearest-even.
module fp_add32
  import fp_series_add_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
`ifdef FP_SERIES_ADD_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  fp32_t fa, fb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sub, a_ge, big_sign, rnd_up;
  logic [EXP_W-1:0]  big_exp, sml_exp, d;
  logic [MANT_W-1:0] big_mant, sml_mant, mant;
  logic [49:0] sh;
  logic [26:0] m_big, m_sml, n;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [24:0] mr;
  logic signed [9:0] e, e_f;

  always_comb begin
    fa = a;
    fb = b;
    a_nan  = (fa.exp == 8'hFF) && (fa.mant != '0);
    b_nan  = (fb.exp == 8'hFF) && (fb.mant != '0);
    a_inf  = (fa.exp == 8'hFF) && (fa.mant == '0);
    b_inf  = (fb.exp == 8'hFF) && (fb.mant == '0);
    a_zero = (fa.exp == '0);
    b_zero = (fb.exp == '0);
    sub    = a[SIGN_BIT] ^ b[SIGN_BIT];

    a_ge     = {fa.exp, fa.mant} >= {fb.exp, fb.mant};
    big_sign = a_ge ? fa.sign : fb.sign;
    big_exp  = a_ge ? fa.exp  : fb.exp;
    big_mant = a_ge ? fa.mant : fb.mant;
    sml_exp  = a_ge ? fb.exp  : fa.exp;
    sml_mant = a_ge ? fb.mant : fa.mant;
    d        = big_exp - sml_exp;

    // 27-bit working format: hidden, 23 mantissa, guard, round, sticky
    m_big = {1'b1, big_mant, 3'b000};
    sh    = {1'b1, sml_mant, 26'd0} >> d;
    m_sml = {sh[49:24], (|sh[23:0]) | (d >= 8'd50)};
    sum   = sub ? ({1'b0, m_big} - {1'b0, m_sml}) : ({1'b0, m_big} + {1'b0, m_sml});

    lz = lzc28(sum);
    if (sum[27]) n = {sum[27:2], |sum[1:0]};
    else         n = sum[26:0] << (lz - 5'd1);
    e = $signed({2'b00, big_exp}) + 10'sd1 - $signed({5'b00000, lz});

    rnd_up = RNE && n[2] && (n[3] || n[1] || n[0]);
    mr     = {1'b0, n[26:3]} + 25'(rnd_up);
    mant   = mr[24] ? mr[23:1] : mr[22:0];
    e_f    = e + $signed({9'd0, mr[24]});

    if (a_nan || b_nan || (a_inf && b_inf && sub)) y = QNAN;
    else if (a_inf)                                y = a;
    else if (b_inf)                                y = b;
    else if (a_zero && b_zero)                     y = {fa.sign & fb.sign, 31'd0};
    else if (a_zero)                               y = b;
    else if (b_zero)                               y = a;
    else if (sum == '0)                            y = POS_ZERO;
    else if (e_f >= 10'(EXP_MAX))                  y = {big_sign, 8'hFF, 23'd0};
    else if (e_f <= 10'sd0)                        y = {big_sign, 31'd0};
    else                                           y = {big_sign, e_f[7:0], mant};
  end
endmodule

// File: rtl/fp_series_add.sv
// Serial accumulator: sums every N consecutive float samples, result on sum_out.
// Optional FP_SERIES_ADD_RNE_EN switches the adder to round-to-nearest-even.
module fp_series_add
  import fp_series_add_pkg::*;
#(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  output logic [31:0] sum_out
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt;
  logic [31:0]   acc, acc_sum;

  fp_add32 u_add (.a(acc), .b(data), .y(acc_sum));

  // cnt==0 marks the first sample of a series; with N==1 every sample is first and last
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      acc     <= POS_ZERO;
      sum_out <= POS_ZERO;
    end else begin
      acc <= (cnt == '0) ? data : acc_sum;
      if (cnt == LAST) begin
        sum_out <= (cnt == '0) ? data : acc_sum;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fp_series_add.sv
// Bench for fp_series_add: an N=8 and an N=2 instance checked against a result queue.
module tb_fp_series_add;
  logic        clk = 1'b0;
  logic        rst8, rst2;
  logic [31:0] data8, data2, sum8, sum2;
  logic [31:0] last8 = '0, last2 = '0;
  logic [31:0] q8[$], q2[$];
  int checks = 0, errors = 0, k8 = 0, k2 = 0;

  typedef struct { logic [31:0] a, b, y; } vec_t;
  vec_t tbl[12];

`ifdef FP_SERIES_ADD_RNE_EN
  localparam logic [31:0] EXP_GR   = 32'h3F80_0001;
  localparam logic [31:0] EXP_HALF = 32'h4040_0000;
`else
  localparam logic [31:0] EXP_GR   = 32'h3F80_0000;
  localparam logic [31:0] EXP_HALF = 32'h403F_FFFF;
`endif

  always #5 clk = ~clk;

  fp_series_add #(.N(8)) dut8 (.clk(clk), .reset(rst8), .data(data8), .sum_out(sum8));
  fp_series_add #(.N(2)) dut2 (.clk(clk), .reset(rst2), .data(data2), .sum_out(sum2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Bench-side sample counters decide when a result is due; otherwise the output must hold.
  always @(posedge clk) begin
    if (!rst8) begin
      k8 = 0; last8 = '0;
    end else begin
      k8++;
      #1;
      if (k8 == 8) begin
        k8 = 0;
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb8_empty: got result %h, want none", sum8);
        end else begin
          last8 = q8.pop_front();
          check("sum8", sum8, last8);
        end
      end else check("hold8", sum8, last8);
    end
  end

  always @(posedge clk) begin
    if (!rst2) begin
      k2 = 0; last2 = '0;
    end else begin
      k2++;
      #1;
      if (k2 == 2) begin
        k2 = 0;
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb2_empty: got result %h, want none", sum2);
        end else begin
          last2 = q2.pop_front();
          check("sum2", sum2, last2);
        end
      end else check("hold2", sum2, last2);
    end
  end

  task automatic drive8(input logic [31:0] s0, input logic [31:0] s1,
                        input logic [31:0] rest, input logic [31:0] exp);
    q8.push_back(exp);
    for (int i = 0; i < 8; i++) begin
      data8 = (i == 0) ? s0 : (i == 1) ? s1 : rest;
      @(negedge clk);
    end
  endtask

  task automatic drive2(input vec_t v);
    q2.push_back(v.y);
    data2 = v.a;
    @(negedge clk);
    data2 = v.b;
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000};
    tbl[1]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000};
    tbl[2]  = '{32'h3F80_0000, 32'h33C0_0000, EXP_GR};
    tbl[3]  = '{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000};
    tbl[4]  = '{32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000};
    tbl[5]  = '{32'h0080_0000, 32'h8080_0001, 32'h8000_0000};
    tbl[6]  = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
    tbl[7]  = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    tbl[8]  = '{32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000};
    tbl[9]  = '{32'h4000_0000, 32'h4040_0000, 32'h40A0_0000};
    tbl[10] = '{32'h3FFF_FFFF, 32'h3F80_0000, EXP_HALF};
    tbl[11] = '{32'h3F80_0000, 32'hB3C0_0000, 32'h3F7F_FFFE};

    rst8 = 1'b1; rst2 = 1'b1; data8 = '0; data2 = '0;
    #2 rst8 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    check("reset8", sum8, 32'h0);
    check("reset2", sum2, 32'h0);

    @(negedge clk);
    rst2 = 1'b1;
    foreach (tbl[i]) drive2(tbl[i]);
    checks++;
    if (q2.size() != 0) begin
      errors++;
      $display("FAIL sb2_drain: got %0d pending, want 0", q2.size());
    end
    rst2 = 1'b0;

    rst8 = 1'b1;
    drive8(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h4100_0000);
    drive8(32'h3FC0_0000, 32'hBFC0_0000, 32'h4000_0000, 32'h4140_0000);
    drive8(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    drive8(32'h3F80_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h40A0_0000);

    // abort a series part-way through with an asynchronous reset
    for (int i = 0; i < 5; i++) begin
      data8 = 32'h40E0_0000;
      @(negedge clk);
    end
    #2 rst8 = 1'b0;
    #1 check("async_rst8", sum8, 32'h0);
    @(negedge clk);
    rst8 = 1'b1;
    drive8(32'h4040_0000, 32'h4040_0000, 32'h4040_0000, 32'h41C0_0000);
    checks++;
    if (q8.size() != 0) begin
      errors++;
      $display("FAIL sb8_drain: got %0d pending, want 0", q8.size());
    end
    rst8 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_series_add.md
Name: fp_series_add

Overview:
- Serial accumulator of IEEE-754 single-precision values.
- Samples one 32-bit float on `data` every clock and sums a series of N consecutive samples.
- Presents the completed series sum on `sum_out`, then starts the next series automatically.
- Sits behind a streaming source that supplies one operand per cycle with no handshake.

Parameters:
- N, 8, number of samples per series (must be at least 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data  input  32  IEEE-754 single operand: {sign, exp[7:0], mant[22:0]}; sampled every cycle while reset is high.
- sum_out  output  32  registered sum of the most recently completed series of N samples.

Behaviour:
- State:
  - cnt, width clog2(N), at least 1 bit.
  - acc, 32 bits.
  - sum_out register.
- Reset (reset=0, asynchronous):
  - cnt=0, acc=0x00000000, sum_out=0x00000000.
  - Takes effect immediately, including mid-series; the partial sum is discarded.
- Each rising edge with reset=1:
  - If cnt==0: acc <= data. Otherwise: acc <= fp_add(acc, data).
  - If cnt==N-1: sum_out <= (N==1 ? data : fp_add(acc, data)); cnt <= 0. Otherwise cnt <= cnt+1; sum_out holds.
- Latency: sum_out reflects the Nth sample on the same edge that samples it. First result appears N edges after reset release. No gaps between series.
- fp_add is single-cycle combinational. Steps: unpack, align smaller operand by exponent difference with guard/round/sticky bits, add or subtract magnitudes, normalize (leading-zero count), round, repack.
- Rounding: round toward zero by default; see Optional Feature.
- Denormals: inputs with exp==0 are treated as signed zero (flush-to-zero). Results below the minimum normal are flushed to zero, keeping the result sign.
- Zero results: exact cancellation x+(-x) gives +0. (-0)+(-0) gives -0.
- Special values, in priority order:
  - Any NaN input gives 0x7FC00000.
  - +Inf + -Inf gives 0x7FC00000.
  - Inf + finite gives that Inf.
  - Overflow (exponent after rounding reaches 255) gives signed Inf, in both rounding modes.
- Once acc holds NaN or Inf, the rest of that series follows the rules above.

Optional Feature:
- Macro FP_SERIES_ADD_RNE_EN.
- Defined: round-to-nearest-even using guard/round/sticky; a mantissa carry-out on rounding increments the exponent.
- Undefined: truncation (round toward zero); guard/round/sticky are discarded.
- Port list and timing are identical in both builds.

Decomposition:
- Package fp_series_add_pkg holds:
  - Constants: SIGN_BIT=31, EXP_W=8, MANT_W=23, EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, POS_ZERO=32'h0.
  - A packed struct typedef for the {sign, exp, mant} fields.
- One combinational sub-module fp_add32 with inputs a[31:0], b[31:0] and output y[31:0]. It contains all adder and rounding logic; the top holds only the counter and registers.

Test Plan:
- N=8, reset pulsed then released, 8 × 0x3F800000 (1.0) → sum_out=0x41000000 (8.0) on the 8th edge. sum_out stays 0 before that.
- N=8, series 1.5, -1.5, then 6 × 0x40000000 (2.0) → 0x41400000 (12.0). Next series of 8 × 0 → 0x00000000, with no idle cycle between series.
- N=2, 0x7F800000 + 0xFF800000 → 0x7FC00000. Then 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
- N=2, 0x3F800000 + 0x33C00000 (1.5·2^-24):
  - With FP_SERIES_ADD_RNE_EN → 0x3F800001.
  - Without → 0x3F800000.
  - Also with the macro, 0x3F800000 + 0x33800000 (exact tie) → 0x3F800000.
- N=8, reset asserted asynchronously after 5 samples → sum_out=0 immediately. After release, 8 × 0x40400000 (3.0) → 0x41C00000 (24.0), with no contribution from the aborted samples.
- N=2, denormal 0x00000001 + 0x3F800000 → 0x3F800000. Then 0x00800000 + 0x80800001 → 0x80000000 (underflow flushed to zero, result sign kept).
